// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind game core.
//   game_state_t  : top-level game phases (load, play, grading, won, lost)
//   grade_phase_t : grader sequencing (idle, exact pass, colour pass, done)
//   count_width() : bits needed to hold a count in the range 0..max_value
package mastermind_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_PLAY,
    ST_GRADE,
    ST_WON,
    ST_LOST
  } game_state_t;

  typedef enum logic [1:0] {
    GP_IDLE,
    GP_EXACT,
    GP_COLOR,
    GP_DONE
  } grade_phase_t;

  function automatic int count_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/mm_grader.sv
// Iterative guess grader.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   start               : one-cycle request; guess is captured on that edge
//   clear               : zero the reported znarly/zood (game restart)
//   guess, pattern      : packed pegs, peg i at [i*COLOR_BITS +: COLOR_BITS]
//   busy                : high from the edge after start until grade_valid
//   done                : high during the final grading cycle
//   exact_count         : running exact count (final while done is high)
//   znarly, zood        : registered result of the last completed grade
//   grade_valid         : one-cycle pulse when znarly/zood update
// Sequencing: NUM_PEGS cycles of exact matching (one peg per cycle), then
// NUM_COLORS cycles of colour matching (one colour per cycle), then one
// cycle to publish the result.
module mm_grader
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS   = 4,
  parameter int COLOR_BITS = 3,
  parameter int NUM_COLORS = 6
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                clear,
  input  logic [NUM_PEGS*COLOR_BITS-1:0]      guess,
  input  logic [NUM_PEGS*COLOR_BITS-1:0]      pattern,
  output logic                                busy,
  output logic                                done,
  output logic [count_width(NUM_PEGS)-1:0]    exact_count,
  output logic [count_width(NUM_PEGS)-1:0]    znarly,
  output logic [count_width(NUM_PEGS)-1:0]    zood,
  output logic                                grade_valid
);

  localparam int CNT_W  = count_width(NUM_PEGS);
  localparam int PIDX_W = $clog2(NUM_PEGS);

  grade_phase_t                   phase;
  grade_phase_t                   phase_next;
  logic [NUM_PEGS*COLOR_BITS-1:0] guess_q;
  logic [PIDX_W-1:0]              peg_idx;
  logic [COLOR_BITS-1:0]          color_idx;
  logic [NUM_PEGS-1:0]            unmatched;
  logic [CNT_W-1:0]               exact_cnt;
  logic [CNT_W-1:0]               partial_cnt;
  logic [COLOR_BITS-1:0]          guess_peg;
  logic [COLOR_BITS-1:0]          pattern_peg;
  logic [CNT_W-1:0]               guess_hits;
  logic [CNT_W-1:0]               pattern_hits;
  logic [CNT_W-1:0]               min_hits;

  assign guess_peg   = guess_q[int'(peg_idx)*COLOR_BITS +: COLOR_BITS];
  assign pattern_peg = pattern[int'(peg_idx)*COLOR_BITS +: COLOR_BITS];

  // Occurrences of the current colour among pegs that missed an exact match,
  // counted separately on the guess and pattern side.
  always_comb begin
    guess_hits   = '0;
    pattern_hits = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (unmatched[i]) begin
        if (guess_q[i*COLOR_BITS +: COLOR_BITS] == color_idx)
          guess_hits = guess_hits + CNT_W'(1);
        if (pattern[i*COLOR_BITS +: COLOR_BITS] == color_idx)
          pattern_hits = pattern_hits + CNT_W'(1);
      end
    end
    min_hits = (guess_hits < pattern_hits) ? guess_hits : pattern_hits;
  end

  always_comb begin
    phase_next = phase;
    case (phase)
      GP_IDLE:  if (start) phase_next = GP_EXACT;
      GP_EXACT: if (peg_idx == PIDX_W'(NUM_PEGS - 1)) phase_next = GP_COLOR;
      GP_COLOR: if (color_idx == COLOR_BITS'(NUM_COLORS - 1)) phase_next = GP_DONE;
      GP_DONE:  phase_next = GP_IDLE;
      default:  phase_next = GP_IDLE;
    endcase
  end

  // Reset here aborts any grade in flight without publishing a result.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase       <= GP_IDLE;
      guess_q     <= '0;
      peg_idx     <= '0;
      color_idx   <= '0;
      unmatched   <= '0;
      exact_cnt   <= '0;
      partial_cnt <= '0;
      znarly      <= '0;
      zood        <= '0;
      grade_valid <= 1'b0;
    end else begin
      phase       <= phase_next;
      grade_valid <= 1'b0;
      if (clear) begin
        znarly <= '0;
        zood   <= '0;
      end
      case (phase)
        GP_IDLE: begin
          if (start) begin
            guess_q     <= guess;
            peg_idx     <= '0;
            color_idx   <= '0;
            unmatched   <= '0;
            exact_cnt   <= '0;
            partial_cnt <= '0;
          end
        end
        GP_EXACT: begin
          if (guess_peg == pattern_peg)
            exact_cnt <= exact_cnt + CNT_W'(1);
          else
            unmatched[peg_idx] <= 1'b1;
          peg_idx <= peg_idx + PIDX_W'(1);
        end
        GP_COLOR: begin
          partial_cnt <= partial_cnt + min_hits;
          color_idx   <= color_idx + COLOR_BITS'(1);
        end
        GP_DONE: begin
          znarly      <= exact_cnt;
          zood        <= partial_cnt;
          grade_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (phase != GP_IDLE);
  assign done        = (phase == GP_DONE);
  assign exact_count = exact_cnt;

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind game core: hidden-pattern loading, guess acceptance, round
// counting and win/loss decisions; grading is delegated to mm_grader.
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   start_game                   : begin play from LOAD, restart from WON/LOST
//   load_color, color_to_load,
//   color_location               : write one peg of the hidden pattern in LOAD
//   guess, grade_it              : packed guess and submit strobe (PLAY only)
//   round_number                 : guesses consumed so far
//   znarly, zood, grade_valid    : result of the last graded guess
//   bad_guess                    : pulse for a rejected guess or illegal load
//   loading, busy, won, lost     : status
module mastermind_engine
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS   = 4,
  parameter int COLOR_BITS = 3,
  parameter int NUM_COLORS = 6,
  parameter int MAX_ROUNDS = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start_game,
  input  logic                                load_color,
  input  logic [COLOR_BITS-1:0]               color_to_load,
  input  logic [$clog2(NUM_PEGS)-1:0]         color_location,
  input  logic [NUM_PEGS*COLOR_BITS-1:0]      guess,
  input  logic                                grade_it,
  output logic [count_width(MAX_ROUNDS)-1:0]  round_number,
  output logic [count_width(NUM_PEGS)-1:0]    znarly,
  output logic [count_width(NUM_PEGS)-1:0]    zood,
  output logic                                grade_valid,
  output logic                                bad_guess,
  output logic                                loading,
  output logic                                busy,
  output logic                                won,
  output logic                                lost
);

  localparam int CNT_W   = count_width(NUM_PEGS);
  localparam int ROUND_W = count_width(MAX_ROUNDS);

  game_state_t                    state;
  game_state_t                    state_next;
  logic [NUM_PEGS*COLOR_BITS-1:0] pattern;
  logic [NUM_PEGS-1:0]            loaded;
  logic [ROUND_W-1:0]             round_q;
  logic                           bad_q;
  logic                           guess_legal;
  logic                           load_legal;
  logic                           grade_start;
  logic                           restart;
  logic                           grader_busy;
  logic                           grader_done;
  logic [CNT_W-1:0]               grader_exact;

  // A guess is only graded when every peg names a legal colour.
  always_comb begin
    guess_legal = 1'b1;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (int'(guess[i*COLOR_BITS +: COLOR_BITS]) >= NUM_COLORS)
        guess_legal = 1'b0;
    end
  end

  assign load_legal  = (int'(color_to_load) < NUM_COLORS);
  assign grade_start = (state == ST_PLAY) && grade_it && guess_legal;
  assign restart     = ((state == ST_WON) || (state == ST_LOST)) && start_game;

  // The win/loss decision uses the grader's final exact count during its
  // done cycle, so the game state and the published result change together.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:  if (start_game && (&loaded)) state_next = ST_PLAY;
      ST_PLAY:  if (grade_start) state_next = ST_GRADE;
      ST_GRADE: begin
        if (grader_done) begin
          if (grader_exact == CNT_W'(NUM_PEGS))
            state_next = ST_WON;
          else if (round_q == ROUND_W'(MAX_ROUNDS))
            state_next = ST_LOST;
          else
            state_next = ST_PLAY;
        end
      end
      ST_WON, ST_LOST: if (start_game) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  // Start in LOAD looks at the loaded flags before this cycle's load lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_LOAD;
      pattern <= '0;
      loaded  <= '0;
      round_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state <= state_next;
      bad_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (load_color) begin
            if (load_legal) begin
              if (int'(color_location) < NUM_PEGS) begin
                pattern[int'(color_location)*COLOR_BITS +: COLOR_BITS] <= color_to_load;
                loaded[color_location] <= 1'b1;
              end
            end else begin
              bad_q <= 1'b1;
            end
          end
          if (start_game && (&loaded))
            round_q <= '0;
        end
        ST_PLAY: begin
          if (grade_it) begin
            if (guess_legal)
              round_q <= round_q + ROUND_W'(1);
            else
              bad_q <= 1'b1;
          end
        end
        ST_WON, ST_LOST: begin
          if (start_game) begin
            loaded  <= '0;
            round_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  mm_grader #(
    .NUM_PEGS   (NUM_PEGS),
    .COLOR_BITS (COLOR_BITS),
    .NUM_COLORS (NUM_COLORS)
  ) u_grader (
    .clock       (clock),
    .reset       (reset),
    .start       (grade_start),
    .clear       (restart),
    .guess       (guess),
    .pattern     (pattern),
    .busy        (grader_busy),
    .done        (grader_done),
    .exact_count (grader_exact),
    .znarly      (znarly),
    .zood        (zood),
    .grade_valid (grade_valid)
  );

  assign round_number = round_q;
  assign bad_guess    = bad_q;
  assign busy         = grader_busy;
  assign loading      = (state == ST_LOAD);
  assign won          = (state == ST_WON);
  assign lost         = (state == ST_LOST);

endmodule

// File: doc/mastermind_engine.md
Name: mastermind_engine

Overview:
Parametrised game core for the Mastermind lab series. It holds a hidden pattern of NUM_PEGS colours, loaded peg by peg, and accepts guesses for up to MAX_ROUNDS rounds. It grades each guess with a multi-cycle iterative grader that reports znarly (right colour, right place) and zood (right colour, wrong place), then declares won or lost. It sits between the switch/button front end and the display/neopixel drivers, and generalises the fixed 4-peg, 8-colour game in peg count, colour count and round limit. New features: invalid-guess rejection and restart from the end states.

Parameters:
NUM_PEGS, 4, pegs per pattern (≥2)
COLOR_BITS, 3, bits per peg colour
NUM_COLORS, 6, legal colours are 0..NUM_COLORS-1 (≤ 2**COLOR_BITS)
MAX_ROUNDS, 8, guesses allowed before loss (≥1)

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high
start_game  input  1  level; begin play from LOAD, or restart from WON/LOST
load_color  input  1  write color_to_load into the hidden pattern at color_location
color_to_load  input  COLOR_BITS  colour to load
color_location  input  $clog2(NUM_PEGS)  peg index to load
guess  input  NUM_PEGS*COLOR_BITS  peg i = guess[i*COLOR_BITS +: COLOR_BITS]
grade_it  input  1  submit guess (sampled in PLAY only)
round_number  output  $clog2(MAX_ROUNDS+1)  guesses consumed so far
znarly  output  $clog2(NUM_PEGS+1)  exact matches of last graded guess
zood  output  $clog2(NUM_PEGS+1)  colour-only matches of last graded guess
grade_valid  output  1  one-cycle pulse: znarly/zood are updated
bad_guess  output  1  one-cycle pulse: guess rejected
loading  output  1  high in LOAD
busy  output  1  high while grading
won  output  1  high in WON
lost  output  1  high in LOST

Behaviour:
- Reset (synchronous, active-high) enters LOAD from any state, including mid-grade; a grade in progress is aborted with no grade_valid pulse.
- Reset values: round_number=0, znarly=0, zood=0, grade_valid=0, bad_guess=0, busy=0, won=0, lost=0, loading=1. All pattern loaded-flags are cleared; pattern contents are don't-care.
- States: LOAD, PLAY, G_EXACT, G_COLOR, G_DONE, WON, LOST.
- LOAD:
  - load_color writes pattern[color_location] and sets loaded[color_location]. Reloading a peg overwrites it.
  - A load of a colour ≥ NUM_COLORS is ignored and pulses bad_guess.
  - start_game with all loaded flags set → PLAY, round_number=0.
  - start_game while any peg is unloaded is ignored (stay in LOAD).
  - If load_color and start_game are both high, the load is performed and start is evaluated against the flags as they stood before the load.
- PLAY:
  - grade_it with every guess peg < NUM_COLORS: latch guess, increment round_number, busy=1 → G_EXACT.
  - grade_it with any illegal peg: bad_guess pulses the next cycle, round_number is unchanged, stay in PLAY.
  - Guess changes after grade_it is accepted have no effect.
- G_EXACT: NUM_PEGS cycles, one peg per cycle.
  - If the latched guess peg equals the pattern peg, the exact counter increments.
  - Otherwise the peg index is recorded in an unmatched mask.
- G_COLOR: NUM_COLORS cycles, one colour c per cycle.
  - Count c among unmatched guess pegs and among unmatched pattern pegs.
  - Add the minimum of the two counts to the partial counter.
- G_DONE: one cycle. Register znarly/zood, pulse grade_valid, busy=0. Next state:
  - znarly==NUM_PEGS → WON.
  - Else round_number==MAX_ROUNDS → LOST.
  - Else → PLAY.
- Latency: grade_it sampled at edge T; grade_valid is high in the cycle after edge T+NUM_PEGS+NUM_COLORS+1. With defaults that is 11 edges.
- WON/LOST hold won/lost, round_number, znarly and zood; grade_it is ignored. start_game → LOAD: clear loaded flags, round_number=0, znarly=zood=0.
- Counters never exceed their bounds: znarly+zood ≤ NUM_PEGS, round_number ≤ MAX_ROUNDS.

Decomposition:
- Package mastermind_pkg: state enum type (name() usable by benches) and a width helper function clog2-based for count/round widths.
- One sub-module, mm_grader: holds G_EXACT/G_COLOR/G_DONE sequencing and the counters. Handshake is start/busy/done. The top-level FSM owns LOAD/PLAY/WON/LOST, the pattern register and the round counter.

Test Plan:
- Load 0→1, 1→2, 2→3, 3→4 then start_game; guess 12'o4321 + grade_it → grade_valid exactly 11 edges later, znarly=4, zood=0, won=1, round_number=1.
- Same pattern, guess 12'o1234 → znarly=0, zood=4, state PLAY, round_number=1; then guess 12'o1111 → znarly=1, zood=0, round_number=2.
- Load only pegs 0..2 then start_game → stays LOAD, loading=1; load peg 3 then start_game → PLAY.
- In PLAY, guess 12'o0700 (colour 7 ≥ 6) + grade_it → bad_guess pulse, round_number unchanged, no grade_valid.
- 8 wrong guesses (12'o5555) → after the 8th grade_valid, lost=1 and round_number=8; a 9th grade_it is ignored; start_game → LOAD with round_number=0.
- Reset asserted 5 cycles into grading → next cycle LOAD, busy=0, no grade_valid, all loaded flags cleared.
